// File: rtl/hazard_unit.sv
// ============================================================================
// Module   : hazard_unit
// Brief    : 5-stage MIPS hazard/forwarding controller with stall FSM,
//            consecutive-stall watchdog and optional perf counters (HAZARD_PERF_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             branch_id,
    input  logic             branch_taken_id,
    input  logic [4:0]       rs_ex,
    input  logic [4:0]       rt_ex,
    input  logic [4:0]       write_reg_ex,
    input  logic             regwrite_ex,
    input  logic             memtoreg_ex,
    input  logic [4:0]       write_reg_mem,
    input  logic             regwrite_mem,
    input  logic             memtoreg_mem,
    input  logic [4:0]       write_reg_wb,
    input  logic             regwrite_wb,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [1:0]       forward_a_id,
    output logic [1:0]       forward_b_id,
    output logic             stall,
    output logic             flush_ex,
    output logic             flush_id,
    output logic [1:0]       hz_state,
    output logic             hazard_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] forward_events
);

    localparam int               c_RUN_W   = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(MAX_STALL);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_RUN_W-1:0]   r_run;
    logic                 r_error;
    logic                 w_ex_hit;
    logic                 w_mem_hit;
    logic                 w_load_use;
    logic                 w_br_haz;

    // Register $0 is hardwired, so it never matches a producer.
    function automatic logic f_match(input logic [4:0] src, input logic wr_en, input logic [4:0] dst);
        return wr_en && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] f_fwd(input logic [4:0] src);
        if (f_match(src, regwrite_mem, write_reg_mem) && !memtoreg_mem)
            return 2'b01;
        else if (f_match(src, regwrite_wb, write_reg_wb))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign w_ex_hit   = f_match(rs_id, regwrite_ex, write_reg_ex) ||
                        f_match(rt_id, regwrite_ex, write_reg_ex);
    assign w_mem_hit  = f_match(rs_id, regwrite_mem, write_reg_mem) ||
                        f_match(rt_id, regwrite_mem, write_reg_mem);
    assign w_load_use = memtoreg_ex && w_ex_hit;
    assign w_br_haz   = branch_id && (w_ex_hit || (memtoreg_mem && w_mem_hit));

    always_comb begin
        forward_a    = 2'b00;
        forward_b    = 2'b00;
        forward_a_id = 2'b00;
        forward_b_id = 2'b00;
        stall        = 1'b0;
        flush_ex     = 1'b0;
        flush_id     = 1'b0;
        if (reset_n) begin
            forward_a    = f_fwd(rs_ex);
            forward_b    = f_fwd(rt_ex);
            forward_a_id = f_fwd(rs_id);
            forward_b_id = f_fwd(rt_id);
            stall        = w_load_use || w_br_haz;
            flush_ex     = w_load_use || w_br_haz;
            // A stalled branch is re-resolved next cycle, so it must not squash yet.
            flush_id     = branch_taken_id && branch_id && !(w_load_use || w_br_haz);
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (stall)
            w_state_nxt = ST_STALL;
        else if (flush_id)
            w_state_nxt = ST_FLUSH;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    // Run length saturates at MAX_STALL; one more stall cycle trips the sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run   <= '0;
            r_error <= 1'b0;
        end else if (stall) begin
            if (r_run == c_RUN_MAX)
                r_error <= 1'b1;
            else
                r_run <= r_run + c_RUN_W'(1);
        end else begin
            r_run <= '0;
        end
    end

    assign hz_state     = r_state;
    assign hazard_error = r_error;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;
    logic [2:0]       w_fwd_inc;

    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign w_fwd_inc = {2'b00, |forward_a} + {2'b00, |forward_b} +
                       {2'b00, |forward_a_id} + {2'b00, |forward_b_id};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            r_stall_cnt <= f_sat_add(r_stall_cnt, CNT_W'(stall));
            r_flush_cnt <= f_sat_add(r_flush_cnt, CNT_W'(flush_id));
            r_fwd_cnt   <= f_sat_add(r_fwd_cnt, CNT_W'(w_fwd_inc));
        end
    end

    assign stall_cycles   = r_stall_cnt;
    assign flush_events   = r_flush_cnt;
    assign forward_events = r_fwd_cnt;
`else
    assign stall_cycles   = '0;
    assign flush_events   = '0;
    assign forward_events = '0;
`endif

endmodule

`default_nettype wire
